reg_file_cmd_ctrl: RTL and testbench
====================================

REG_FILE_CMD_CTRL -- requirements
Module: reg_file_cmd_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 3, register-file address width (1..6).
REQ-002 SHALL have parameter: reg_WIDTH, 16, register-file data width (only 16 supported).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: CLK  in  1  rising-edge clock; RST  in  1  async active-low reset.
REQ-004 SHALL have ports: in_data  in  8  command/data byte from host; in_valid  in  1  byte valid; in_ready  out  1  controller accepts byte.
REQ-005 SHALL have ports: out_data  out  8  read-response byte; out_valid  out  1  response byte valid; out_ready  in  1  host accepts byte.
REQ-006 SHALL have ports to the downstream register file: RF_WrEn  out  1; RF_RdEn  out  1; RF_Address  out  ADDR_WIDTH; RF_WrData  out  reg_WIDTH; RF_RdData  in  reg_WIDTH (registered read, valid one edge after RF_RdEn sampled).
REQ-007 SHALL have ports: busy  out  1  frame in progress; cmd_err  out  1  one-cycle illegal-opcode pulse.

Function
REQ-008 SHALL drive every output from a flop.
REQ-009 SHALL transfer a byte on an input or output port only on a rising edge where valid and ready are both 1.
REQ-010 SHALL decode the command byte as opcode = bits[7:6], with 2'b10 = write, 2'b00 = read, 2'b01/2'b11 = illegal, and address = bits[ADDR_WIDTH-1:0].
REQ-011 SHALL implement the states IDLE, WR_MSB, WR_LSB, WR_EXEC, RD_REQ, RD_WAIT, TX_MSB and TX_LSB.
REQ-012 SHALL make transitions: IDLE -write cmd-> WR_MSB -byte-> WR_LSB -byte-> WR_EXEC -> IDLE; IDLE -read cmd-> RD_REQ -> RD_WAIT -> TX_MSB -handshake-> TX_LSB -handshake-> IDLE.
REQ-013 SHALL, on an illegal opcode, consume the byte, pulse cmd_err for one cycle, stay in IDLE, and assert no RF strobe.
REQ-014 SHALL assert in_ready only when the next state is IDLE, WR_MSB or WR_LSB, and SHALL never consume a byte in any other state.
REQ-015 SHALL assemble write data as RF_WrData = {MSB byte, LSB byte}.
REQ-016 SHALL, in WR_EXEC, assert RF_WrEn for exactly one cycle, with RF_Address/RF_WrData stable.
REQ-017 SHALL, in RD_REQ, assert RF_RdEn for exactly one cycle.
REQ-018 SHALL capture RF_RdData into a shadow register at the end of RD_WAIT.
REQ-019 SHALL assert out_valid exactly 3 clocks after the read-command accept edge.
REQ-020 SHALL drive out_data = shadow[15:8] in TX_MSB and shadow[7:0] in TX_LSB.
REQ-021 SHALL hold out_valid/out_data stable until a handshake occurs, and SHALL ignore out_ready while out_valid = 0.
REQ-022 SHALL never assert RF_WrEn and RF_RdEn in the same cycle.
REQ-023 SHALL hold RF_WrEn/RF_RdEn at 0 outside WR_EXEC/RD_REQ.
REQ-024 SHALL hold RF_Address at the last command address between frames.
REQ-025 SHALL tolerate in_valid gaps of any length between frame bytes, with no timeout.
REQ-026 SHALL assert busy = 1 in every state except IDLE.
REQ-027 SHALL start the next command accept no earlier than the edge after the final TX_LSB handshake or the WR_EXEC cycle.

Reset
REQ-028 SHALL, while RST = 0, force state = IDLE and clear in_ready, out_valid, out_data, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, busy, cmd_err and the shadow register to 0.
REQ-029 SHALL, on RST assertion mid-frame, discard the partial frame, drop RF strobes and out_valid immediately, and parse the first byte after release as a command.
REQ-030 SHALL raise in_ready to 1 on the first rising edge after RST release.

Structure
REQ-031 SHALL place the state encoding, the opcode constants (OP_WR = 2'b10, OP_RD = 2'b00) and the default widths in package reg_file_cmd_pkg.
REQ-032 SHALL contain no sub-module; a wrapper reg_file_sys SHALL instantiate this block and the register file.

Verification
REQ-033 SHALL cover: bytes 8'h83, 8'h17, 8'h70 -> one-cycle RF_WrEn with RF_Address = 3 and RF_WrData = 16'h1770, then back to IDLE.
REQ-034 SHALL cover: 8'h03 with the RF model holding 16'h1770 at addr 3 -> RF_RdEn one cycle, out_valid 3 clocks later, bytes 8'h17 then 8'h70.
REQ-035 SHALL cover: out_ready held low 5 cycles during TX_MSB -> out_data stays 8'h17, no RF strobe, in_ready = 0.
REQ-036 SHALL cover: 8'h45 -> one-cycle cmd_err, no RF strobe, and a following 8'h81, 8'h03, 8'h48 writes 16'h0348 to addr 1.
REQ-037 SHALL cover: RST pulsed low after 8'h86, 8'h02 -> no RF_WrEn, all outputs 0, and next bytes 8'h06 read addr 6.
REQ-038 SHALL cover: in_valid gaps of 4 cycles between write bytes -> identical RF_WrEn result, busy = 1 throughout the gaps.

Source files
------------

// File: rtl/reg_file_cmd_pkg.sv
// Shared constants and state encoding for the register-file command controller.
package reg_file_cmd_pkg;

  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEF_REG_WIDTH  = 16;

  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_RD = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_MSB  = 3'd1,
    WR_LSB  = 3'd2,
    WR_EXEC = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    TX_MSB  = 3'd6,
    TX_LSB  = 3'd7
  } cmdState_t;

endpackage

// File: rtl/reg_file_cmd_ctrl.sv
// Byte-stream command parser driving a register file: 3-byte writes, 1-byte reads
// answered with a 2-byte response. Every output comes straight from a flop.
module reg_file_cmd_ctrl
  import reg_file_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned reg_WIDTH  = DEF_REG_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BYTE_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BYTE_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [reg_WIDTH-1:0]  RF_WrData,
  input  logic [reg_WIDTH-1:0]  RF_RdData,
  output logic                  busy,
  output logic                  cmd_err
);

  cmdState_t state, nextState;

  logic                  inFire;
  logic [BYTE_WIDTH-1:0] msbByte, msbByteNext;
  logic [reg_WIDTH-1:0]  shadow, shadowNext;
  logic [ADDR_WIDTH-1:0] addrNext;
  logic [reg_WIDTH-1:0]  wrDataNext;
  logic [BYTE_WIDTH-1:0] outDataNext;
  logic                  outValidNext;
  logic                  inReadyNext;
  logic                  wrEnNext;
  logic                  rdEnNext;
  logic                  busyNext;
  logic                  cmdErrNext;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state decode plus next values for every registered output
  always_comb begin
    nextState    = state;
    inFire       = in_valid && in_ready;
    msbByteNext  = msbByte;
    shadowNext   = shadow;
    addrNext     = RF_Address;
    wrDataNext   = RF_WrData;
    outDataNext  = out_data;
    outValidNext = out_valid;
    cmdErrNext   = 1'b0;

    unique case (state)
      IDLE: begin
        if (inFire) begin
          case (in_data[7:6])
            OP_WR: begin
              nextState = WR_MSB;
              addrNext  = in_data[ADDR_WIDTH-1:0];
            end
            OP_RD: begin
              nextState = RD_REQ;
              addrNext  = in_data[ADDR_WIDTH-1:0];
            end
            default: cmdErrNext = 1'b1;
          endcase
        end
      end
      WR_MSB: begin
        if (inFire) begin
          msbByteNext = in_data;
          nextState   = WR_LSB;
        end
      end
      WR_LSB: begin
        if (inFire) begin
          wrDataNext = reg_WIDTH'({msbByte, in_data});
          nextState  = WR_EXEC;
        end
      end
      WR_EXEC: nextState = IDLE;
      RD_REQ:  nextState = RD_WAIT;
      RD_WAIT: begin
        shadowNext = RF_RdData;
        nextState  = TX_MSB;
      end
      TX_MSB: begin
        // First TX_MSB cycle raises out_valid; out_ready is ignored until then
        if (!out_valid) begin
          outValidNext = 1'b1;
          outDataNext  = shadow[15:8];
        end else if (out_ready) begin
          outDataNext = shadow[7:0];
          nextState   = TX_LSB;
        end
      end
      TX_LSB: begin
        if (out_ready) begin
          outValidNext = 1'b0;
          nextState    = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    wrEnNext    = (nextState == WR_EXEC);
    rdEnNext    = (nextState == RD_REQ);
    inReadyNext = (nextState == IDLE) || (nextState == WR_MSB) || (nextState == WR_LSB);
    busyNext    = (nextState != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
      shadow     <= '0;
      msbByte    <= '0;
    end else begin
      in_ready   <= inReadyNext;
      out_valid  <= outValidNext;
      out_data   <= outDataNext;
      RF_WrEn    <= wrEnNext;
      RF_RdEn    <= rdEnNext;
      RF_Address <= addrNext;
      RF_WrData  <= wrDataNext;
      busy       <= busyNext;
      cmd_err    <= cmdErrNext;
      shadow     <= shadowNext;
      msbByte    <= msbByteNext;
    end
  end

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Randomized bench for reg_file_cmd_ctrl with a behavioural register file and
// a transaction-level reference memory.
module tb_reg_file_cmd_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          RF_WrEn;
  logic          RF_RdEn;
  logic [AW-1:0] RF_Address;
  logic [DW-1:0] RF_WrData;
  logic [DW-1:0] RF_RdData;
  logic          busy;
  logic          cmd_err;

  int nChecks = 0;
  int nFails  = 0;
  int wrCount = 0;
  int rdCount = 0;
  int errCount = 0;

  logic [DW-1:0] rfMem [8] = '{default: 16'h0};
  logic [DW-1:0] refMem [8];

  always #5 CLK = ~CLK;

  reg_file_cmd_ctrl #(.ADDR_WIDTH(AW), .reg_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData),
    .busy(busy), .cmd_err(cmd_err)
  );

  // Register file environment: registered read, one edge after RdEn
  always @(posedge CLK) begin
    if (RF_WrEn) rfMem[RF_Address] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= rfMem[RF_Address];
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe pulse counters and mutual exclusion of the RF strobes
  always @(negedge CLK) begin
    if (RF_WrEn) wrCount++;
    if (RF_RdEn) rdCount++;
    if (cmd_err) errCount++;
    if (RF_WrEn || RF_RdEn) checkEq("strobeExcl", 32'(RF_WrEn & RF_RdEn), 0);
  end

  task automatic chkAllZero(input string tag);
    checkEq({tag, "Ctrl"}, 32'({in_ready, out_valid, RF_WrEn, RF_RdEn, RF_Address, busy, cmd_err}), 0);
    checkEq({tag, "Data"}, 32'({out_data, RF_WrData}), 0);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, input bit busyChk);
    int n;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge CLK); #1;
      if (busyChk) checkEq("gapBusy", 32'(busy), 1);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) checkEq("inReadyTimeout", 32'(in_ready), 1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic doWrite(input logic [7:0] cmd, input logic [15:0] data, input int gap);
    int w0, r0;
    logic [2:0] addr;
    addr = cmd[2:0];
    w0 = wrCount; r0 = rdCount;
    sendByte(cmd, gap, 1'b0);
    checkEq("wrBusy", 32'(busy), 1);
    sendByte(data[15:8], gap, 1'b1);
    sendByte(data[7:0], gap, 1'b1);
    checkEq("wrEn", 32'(RF_WrEn), 1);
    checkEq("wrAddr", 32'(RF_Address), 32'(addr));
    checkEq("wrData", 32'(RF_WrData), 32'(data));
    checkEq("wrInReady", 32'(in_ready), 0);
    @(posedge CLK); #1;
    checkEq("wrEnDrop", 32'(RF_WrEn), 0);
    checkEq("wrIdle", 32'({busy, in_ready}), 32'b01);
    checkEq("wrAddrHold", 32'(RF_Address), 32'(addr));
    checkEq("wrPulses", wrCount - w0, 1);
    checkEq("wrNoRd", rdCount - r0, 0);
    refMem[addr] = data;
  endtask

  task automatic doRead(input logic [7:0] cmd, input int stall, input bit earlyReady);
    int w0, r0, n;
    logic [2:0] addr;
    logic [15:0] exp;
    addr = cmd[2:0];
    exp  = refMem[addr];
    w0 = wrCount; r0 = rdCount;
    sendByte(cmd, 0, 1'b0);
    checkEq("rdEn", 32'(RF_RdEn), 1);
    checkEq("rdInReady", 32'(in_ready), 0);
    checkEq("rdAddr", 32'(RF_Address), 32'(addr));
    out_ready = earlyReady;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) checkEq("rdEnDrop", 32'(RF_RdEn), 0);
    end
    out_ready = 1'b0;
    checkEq("rdLatency", n, 3);
    checkEq("txMsb", 32'(out_data), 32'(exp[15:8]));
    for (int s = 0; s < stall; s++) begin
      @(posedge CLK); #1;
      checkEq("stallData", 32'(out_data), 32'(exp[15:8]));
      checkEq("stallValid", 32'(out_valid), 1);
      checkEq("stallInReady", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    checkEq("txLsb", 32'(out_data), 32'(exp[7:0]));
    checkEq("txLsbValid", 32'(out_valid), 1);
    for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
      @(posedge CLK); #1;
      checkEq("stallLsb", 32'(out_data), 32'(exp[7:0]));
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    checkEq("txDone", 32'({out_valid, busy, in_ready}), 32'b001);
    checkEq("rdPulses", rdCount - r0, 1);
    checkEq("rdNoWr", wrCount - w0, 0);
  endtask

  task automatic doIllegal(input logic [7:0] cmd);
    int w0, r0, e0;
    w0 = wrCount; r0 = rdCount; e0 = errCount;
    sendByte(cmd, 0, 1'b0);
    checkEq("errPulse", 32'(cmd_err), 1);
    checkEq("errIdle", 32'({busy, in_ready}), 32'b01);
    @(posedge CLK); #1;
    checkEq("errDrop", 32'(cmd_err), 0);
    checkEq("errCount", errCount - e0, 1);
    checkEq("errNoStrobe", (wrCount - w0) + (rdCount - r0), 0);
  endtask

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [2:0]  addr;
    int          kind, w0;

    RST       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) refMem[i] = 16'h0;

    repeat (2) @(posedge CLK);
    #1;
    chkAllZero("rst");
    RST = 1'b1;
    checkEq("rstInReady", 32'(in_ready), 0);
    @(posedge CLK); #1;
    checkEq("inReadyRise", 32'(in_ready), 1);
    checkEq("busyIdle", 32'(busy), 0);

    // Directed frames
    doWrite(8'h83, 16'h1770, 0);
    doRead(8'h03, 0, 1'b0);
    doRead(8'h03, 5, 1'b1);
    doIllegal(8'h45);
    doWrite(8'h81, 16'h0348, 0);
    doRead(8'h01, 1, 1'b0);
    doWrite(8'h86, 16'hA5C3, 1);

    // Reset in the middle of a write frame
    w0 = wrCount;
    sendByte(8'h86, 0, 1'b0);
    sendByte(8'h02, 0, 1'b0);
    RST = 1'b0;
    #1;
    chkAllZero("midRst");
    @(posedge CLK); #1;
    RST = 1'b1;
    checkEq("midRstInReady", 32'(in_ready), 0);
    @(posedge CLK); #1;
    checkEq("postRstInReady", 32'(in_ready), 1);
    checkEq("midRstNoWr", wrCount - w0, 0);
    doRead(8'h06, 0, 1'b0);

    // Gapped write frame
    doWrite(8'h83, 16'h1770, 4);
    doRead(8'h03, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 5));
      addr = 3'($urandom);
      if (kind <= 2) begin
        cmd  = {2'b10, 3'($urandom), addr};
        data = 16'($urandom);
        doWrite(cmd, data, int'($urandom_range(0, 4)));
      end else if (kind <= 4) begin
        cmd = {2'b00, 3'($urandom), addr};
        doRead(cmd, int'($urandom_range(0, 3)), 1'($urandom));
      end else begin
        cmd = {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11, 6'($urandom)};
        doIllegal(cmd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
